// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO feeding a UART transmitter one frame at a time, with error count and stuck-frame timeout
// Ports:
//   clk, rst (async, active-low)
//   wr_valid/wr_ready/wr_data : byte write port, wr_ready = ~full
//   flush                     : synchronous FIFO clear, in-flight frame untouched
//   tx_start/tx_data          : registered level request and byte to the transmitter
//   tx_done/tx_err            : transmitter status, asynchronous to clk
//   level/empty/full          : FIFO occupancy 0..DEPTH
//   err_cnt                   : saturating count of frames ended with tx_err
//   timeout                   : one-cycle pulse when a frame is abandoned
module uart_tx_feeder #(
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 65536,
    parameter int GAP_CYC     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [7:0]              wr_data,
    input  logic                    flush,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_done,
    input  logic                    tx_err,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    empty,
    output logic                    full,
    output logic [7:0]              err_cnt,
    output logic                    timeout
);
    localparam int AW   = $clog2(DEPTH);
    localparam int TMAX = TIMEOUT_CYC > GAP_CYC ? TIMEOUT_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, START, GAP} state_t;

    state_t          state, state_n;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [TW-1:0]   timer;
    logic            done_m, done_s, done_q, err_m, err_s;
    logic            done_rise, wr_en, rd_en, to_hit, gap_end;

    assign empty     = level == '0;
    assign full      = level == (AW+1)'(DEPTH);
    assign wr_ready  = ~full;
    assign wr_en     = wr_valid && wr_ready && !flush;
    assign rd_en     = state == LOAD && !empty;
    assign done_rise = done_s & ~done_q;
    assign to_hit    = timer == TW'(TIMEOUT_CYC - 1);
    assign gap_end   = !done_s && timer >= TW'(GAP_CYC - 1);

    // LOAD falls back to IDLE if a flush emptied the FIFO on the way in
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = empty ? IDLE : LOAD;
            LOAD:    state_n = empty ? IDLE : START;
            START:   state_n = (done_rise || to_hit) ? GAP : START;
            GAP:     state_n = gap_end ? IDLE : GAP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            err_cnt  <= 8'h00;
            timeout  <= 1'b0;
            timer    <= '0;
            done_m   <= 1'b0;
            done_s   <= 1'b0;
            done_q   <= 1'b0;
            err_m    <= 1'b0;
            err_s    <= 1'b0;
        end else begin
            state    <= state_n;
            done_m   <= tx_done;
            done_s   <= done_m;
            done_q   <= done_s;
            err_m    <= tx_err;
            err_s    <= err_m;
            tx_start <= state_n == START;
            timeout  <= state == START && !done_rise && to_hit;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (rd_en) rd_ptr <= rd_ptr + 1'b1;
                level <= level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
            end
            if (rd_en) tx_data <= mem[rd_ptr];
            if (state == START && done_rise && err_s && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
            // timer restarts on every state change; in GAP it stops once the minimum gap is met
            timer <= state_n != state ? '0
                   : timer + TW'(state == START || (state == GAP && timer < TW'(GAP_CYC - 1)));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench for uart_tx_feeder (main instance plus a short-timeout instance)
module tb_uart_tx_feeder;
    logic       clk = 0, rst = 0;
    logic       wr_valid, wr_ready, flush, tx_start, tx_done, tx_err, empty, full, timeout;
    logic [7:0] wr_data, tx_data, err_cnt;
    logic [4:0] level;
    logic       wr2_valid, wr2_ready, ts2, empty2, full2, to2;
    logic [7:0] wr2_data, td2, ec2;
    logic [2:0] lvl2;
    logic       md = 0, me = 0, fd = 0, fe = 0, model_on = 0, err_mode = 0, rdy;
    int         done_dly = 100;
    int         checks = 0, failures = 0, rises = 0, r0, acc;
    logic [7:0] sb[$], sb2[$];

    initial forever #5 clk = ~clk;
    assign tx_done = md | fd;
    assign tx_err  = me | fe;

    uart_tx_feeder dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .flush(flush), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .tx_err(tx_err),
        .level(level), .empty(empty), .full(full), .err_cnt(err_cnt), .timeout(timeout)
    );

    uart_tx_feeder #(.DEPTH(4), .TIMEOUT_CYC(64), .GAP_CYC(2)) u_to (
        .clk(clk), .rst(rst), .wr_valid(wr2_valid), .wr_ready(wr2_ready), .wr_data(wr2_data),
        .flush(1'b0), .tx_start(ts2), .tx_data(td2), .tx_done(1'b0), .tx_err(1'b0),
        .level(lvl2), .empty(empty2), .full(full2), .err_cnt(ec2), .timeout(to2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // transmitter model: pulses tx_done (with tx_err if requested) done_dly cycles after each tx_start rise
    initial forever begin
        @(posedge tx_start);
        if (model_on) begin
            repeat (done_dly) @(negedge clk);
            me = err_mode;
            md = 1;
            repeat (4) @(negedge clk);
            md = 0;
            me = 0;
        end
    end

    logic       ts_q = 0;
    logic [7:0] cur = 0;
    always @(negedge clk) begin
        if (tx_start && !ts_q) begin
            rises++;
            cur <= tx_data;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: tx_data=%0h with nothing queued", tx_data);
            end else check("sb_tx_data", tx_data, sb.pop_front());
        end
        if (!tx_start && ts_q && rst) check("tx_data_hold", tx_data, cur);
        ts_q <= tx_start;
    end

    logic ts2_q = 0;
    int   cyc = 0, rise2 = 0, to2_cnt = 0, rise2_cyc = 0, to2_cyc = -1;
    always @(negedge clk) begin
        cyc++;
        if (ts2 && !ts2_q) begin
            rise2++;
            if (to2_cyc >= 0) check("gap_restart_cycles", cyc - to2_cyc, 4);
            rise2_cyc = cyc;
            if (sb2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb2_unexpected: tx_data=%0h with nothing queued", td2);
            end else check("to_tx_data", td2, sb2.pop_front());
        end
        if (to2) begin
            to2_cnt++;
            check("timeout_delay", cyc - rise2_cyc, 64);
            check("timeout_drops_start", ts2, 0);
            to2_cyc = cyc;
        end
        ts2_q <= ts2;
    end

    task automatic push_byte(input logic [7:0] d);
        int g = 0;
        wr_valid = 1;
        wr_data  = d;
        while (!wr_ready && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: wr_ready=%0d expected 1", wr_ready);
        end else begin
            @(negedge clk);
            sb.push_back(d);
        end
    endtask

    task automatic drain(input int budget);
        int g = 0;
        while (!(sb.size() == 0 && !tx_start && empty) && g < budget) begin
            @(negedge clk);
            g++;
        end
        check("drain_in_budget", int'(g < budget), 1);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        wr_valid = 0; wr_data = 0; flush = 0; wr2_valid = 0; wr2_data = 0;
        // 1: reset with inputs toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_valid = i[0]; wr_data = 8'(i * 37); flush = i[1]; fd = i[0]; fe = ~i[0]; wr2_valid = i[0];
        end
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_timeout", timeout, 0);
        check("rst_to_level", lvl2, 0);
        @(negedge clk);
        wr_valid = 0; flush = 0; fd = 0; fe = 0; wr2_valid = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rel_wr_ready", wr_ready, 1);
        check("rel_empty", empty, 1);
        // 2: three frames with a 100-cycle transmitter
        model_on = 1; done_dly = 100; err_mode = 0; r0 = rises;
        push_byte(8'hA5);
        push_byte(8'h3C);
        push_byte(8'hFF);
        wr_valid = 0;
        drain(2000);
        check("t2_rises", rises - r0, 3);
        check("t2_err_cnt", err_cnt, 0);
        check("t2_level", level, 0);
        // 4: short-timeout instance, latency and back-to-back timeouts
        wr2_valid = 1; wr2_data = 8'h11; sb2.push_back(8'h11);
        @(negedge clk);
        wr2_valid = 0;
        check("lat_level1", lvl2, 1);
        check("lat_start_n0", ts2, 0);
        @(negedge clk);
        check("lat_start_n1", ts2, 0);
        @(negedge clk);
        check("lat_start_n2", ts2, 1);
        wr2_valid = 1; wr2_data = 8'h22; sb2.push_back(8'h22);
        @(negedge clk);
        wr2_valid = 0;
        for (int g = 0; g < 400 && to2_cnt < 2; g++) @(negedge clk);
        check("t4_timeouts", to2_cnt, 2);
        repeat (10) @(negedge clk);
        check("t4_rises", rise2, 2);
        check("t4_level", lvl2, 0);
        // 3: stalled drain, 18 back-to-back writes
        model_on = 0; r0 = rises; acc = 0;
        for (int i = 0; i < 18; i++) begin
            wr_valid = 1; wr_data = 8'(8'h10 + i); rdy = wr_ready;
            @(negedge clk);
            if (rdy) begin
                acc++;
                sb.push_back(8'(8'h10 + i));
            end
        end
        wr_valid = 0;
        check("t3_accepted", acc, 17);
        check("t3_last_ready", rdy, 0);
        check("t3_level", level, 16);
        check("t3_full", full, 1);
        check("t3_wr_ready", wr_ready, 0);
        check("t3_rises", rises - r0, 1);
        // 6: flush keeps frame in flight, flush drops a same-cycle write, reset mid-START
        flush = 1;
        @(negedge clk);
        flush = 0;
        sb.delete();
        check("t6_flush_level", level, 0);
        check("t6_flush_tx_data", tx_data, 8'h10);
        check("t6_flush_tx_start", tx_start, 1);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_data = 8'(8'h40 + i);
            @(negedge clk);
        end
        wr_valid = 0;
        check("t6_refill_level", level, 3);
        flush = 1; wr_valid = 1; wr_data = 8'hEE;
        @(negedge clk);
        flush = 0; wr_valid = 0;
        repeat (3) @(negedge clk);
        check("t6_flush_write_dropped", level, 0);
        check("t6_flush_tx_data2", tx_data, 8'h10);
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1; wr_data = 8'(8'h50 + i);
            @(negedge clk);
        end
        wr_valid = 0;
        check("t6_queued5", level, 5);
        #2 rst = 0;
        #1;
        check("t6_rst_tx_start", tx_start, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_empty", empty, 1);
        check("t6_rst_tx_data", tx_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        // 5: every frame ends with tx_err, err_cnt saturates
        model_on = 1; done_dly = 3; err_mode = 1; r0 = rises;
        for (int i = 0; i < 260; i++) push_byte(8'(i * 7 + 1));
        wr_valid = 0;
        drain(8000);
        check("t5_rises", rises - r0, 260);
        check("t5_err_cnt_sat", err_cnt, 8'hFF);
        check("t5_level", level, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
